inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/inst_fetch.sv | 111 +++++++++++
 tb/tb_inst_fetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: opcode encodings,
// instruction width, default address width and a jump-decode helper.
// No logic lives here; the package is imported by the fetch RTL.
package fetch_pkg;

    localparam int INST_W     = 16;
    localparam int DEFAULT_AW = 8;

    typedef enum logic [2:0] {
        OP_RTYPE = 3'b000,
        OP_ADDI  = 3'b001,
        OP_LOAD  = 3'b010,
        OP_STORE = 3'b011,
        OP_BEQ   = 3'b100,
        OP_JMP   = 3'b101
    } opcode_t;

    // Opcode field is inst[15:13]; only the opcode is passed in.
    function automatic logic is_jump(input logic [2:0] op);
        return op == OP_JMP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of W-bit words with synchronous flush.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
// Ports: clk, rst (async active-low), flush, push/push_data, pop, head, count.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign rd_en = pop && (count != '0);
    assign wr_en = push && ((count != CW'(DEPTH)) || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential prefetch into a small buffer feeding decode.
// Latency: request in cycle N, instruction valid to decode in N+2 at earliest.
// Backpressure: inst_ready=0 holds the head; requests stop once buffer+in-flight fill DEPTH.
// Ports: clk, rst (async active-low, deasserted synchronously by the environment),
//   imem_req/imem_addr/imem_rdata (memory, 1-cycle read), redirect/redirect_pc,
//   inst_valid/inst/inst_pc/inst_ready (decode handshake).
// Optional: FETCH_JUMP_PREDECODE_EN redirects fetch on JMP words as they return.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int AW    = DEFAULT_AW,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [AW-1:0]     redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [AW-1:0]     inst_pc,
    input  logic              inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INST_W + AW;

    logic [AW-1:0] pc;
    logic [AW-1:0] req_pc;     // address of the request now in flight
    logic          inflight;
    logic [CW-1:0] count;
    logic [EW-1:0] head;
    logic          pop;
    logic          resp_vld;
    logic          push;
    logic          jump_taken;
    logic [CW:0]   occ;
    logic [CW:0]   lim;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;

    // Credit check: slots already used (buffered + in flight) against DEPTH,
    // with a same-cycle pop freeing one slot.
    assign occ      = {1'b0, count} + (CW+1)'(inflight);
    assign lim      = (CW+1)'(DEPTH) + (CW+1)'(pop);
    assign imem_req = rst && !redirect && (occ < lim);
    assign imem_addr = pc;

`ifdef FETCH_JUMP_PREDECODE_EN
    // Set when a request went out in the same cycle a jump was decoded;
    // that request's data belongs to the wrong path and is dropped.
    logic discard;

    assign resp_vld   = inflight && !discard;
    assign jump_taken = push && is_jump(imem_rdata[15:13]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            discard <= 1'b0;
        end else begin
            discard <= imem_req && jump_taken;
        end
    end
`else
    assign resp_vld   = inflight;
    assign jump_taken = 1'b0;
`endif

    // A redirect kills whatever response is arriving this cycle.
    assign push = resp_vld && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            req_pc   <= pc;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (jump_taken) begin
                pc <= AW'(imem_rdata[7:0]);
            end else if (imem_req) begin
                pc <= pc + AW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({imem_rdata, req_pc}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Outputs forced to zero when empty so reset and flush present clean values.
    assign inst    = inst_valid ? head[EW-1:AW] : '0;
    assign inst_pc = inst_valid ? head[AW-1:0]  : '0;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int AW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata = '0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          inst_valid;
    logic [15:0]   inst;
    logic [AW-1:0] inst_pc;
    logic          inst_ready = 1'b0;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // One-cycle read memory model.
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    inst_fetch #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 (first cycle after release), outputs settled.
    task automatic release_reset();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        redirect = 1'b0;
        inst_ready = 1'b0;
        repeat (2) next_cycle();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++; if (inst !== 16'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0000", inst); end
        checks++; if (inst_pc !== 8'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00", inst_pc); end
    endtask

    task automatic test_stream();
        inst_ready = 1'b1;
        release_reset();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00", imem_req, imem_addr); end
        next_cycle(); #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_cycle1_valid: got %b expected 0", inst_valid); end
        for (int k = 0; k < 8; k++) begin
            next_cycle(); #1;
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 8'(k) || inst !== 16'(k)) begin
                errors++;
                $display("FAIL stream_seq: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", inst_valid, inst_pc, inst, 8'(k), 16'(k));
            end
        end
    endtask

    task automatic test_stall();
        inst_ready = 1'b0;
        release_reset();
        repeat (3) next_cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst !== 16'h0000) begin
                errors++;
                $display("FAIL stall_hold: got req=%b v=%b pc=%h inst=%h expected req=0 v=1 pc=00 inst=0000", imem_req, inst_valid, inst_pc, inst);
            end
            next_cycle();
        end
        inst_ready = 1'b1;
        #1;
        // Exactly DEPTH words were fetched, so the next address is DEPTH.
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'(DEPTH) || inst_pc !== 8'h00) begin
            errors++;
            $display("FAIL stall_resume: got req=%b addr=%h pc=%h expected req=1 addr=%h pc=00", imem_req, imem_addr, inst_pc, 8'(DEPTH));
        end
        for (int k = 1; k < 4; k++) begin
            next_cycle(); #1;
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 8'(k)) begin
                errors++;
                $display("FAIL stall_drain: got v=%b pc=%h expected v=1 pc=%h", inst_valid, inst_pc, 8'(k));
            end
        end
    endtask

    task automatic test_redirect_full();
        next_cycle();
        inst_ready = 1'b0;
        repeat (3) next_cycle();
        redirect = 1'b1;
        redirect_pc = 8'h40;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_no_req: got %b expected 0", imem_req); end
        next_cycle();
        redirect = 1'b0;
        inst_ready = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
            errors++;
            $display("FAIL redir_next: got v=%b req=%b addr=%h expected v=0 req=1 addr=40", inst_valid, imem_req, imem_addr);
        end
        next_cycle(); #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_gap: got v=%b pc=%h expected v=0", inst_valid, inst_pc); end
        for (int k = 0; k < 4; k++) begin
            next_cycle(); #1;
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 8'(8'h40 + k) || inst !== 16'(8'h40 + k)) begin
                errors++;
                $display("FAIL redir_seq: got v=%b pc=%h inst=%h expected v=1 pc=%h", inst_valid, inst_pc, inst, 8'(8'h40 + k));
            end
        end
    endtask

    // Redirect while a pop and a returning response coincide; target near the top
    // of the address space to also cover the 0xFF -> 0x00 wrap.
    task automatic test_redirect_wrap();
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        #1;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL wrap_pre_valid: got %b expected 1", inst_valid); end
        next_cycle();
        redirect = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wrap_drop1: got v=%b pc=%h expected v=0", inst_valid, inst_pc); end
        next_cycle(); #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wrap_drop2: got v=%b pc=%h expected v=0", inst_valid, inst_pc); end
        for (int k = 0; k < 4; k++) begin
            next_cycle(); #1;
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 8'(8'hFE + k)) begin
                errors++;
                $display("FAIL wrap_seq: got v=%b pc=%h expected v=1 pc=%h", inst_valid, inst_pc, 8'(8'hFE + k));
            end
        end
    endtask

    task automatic test_jump();
        logic [7:0]  pcs [$];
        logic [15:0] insts [$];
        logic [7:0]  exp_pc [6];
`ifdef FETCH_JUMP_PREDECODE_EN
        exp_pc = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11};
`else
        exp_pc = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`endif
        mem[3] = 16'hA010;
        inst_ready = 1'b1;
        release_reset();
        for (int c = 0; c < 12; c++) begin
            if (inst_valid === 1'b1) begin
                pcs.push_back(inst_pc);
                insts.push_back(inst);
            end
            next_cycle(); #1;
        end
        mem[3] = 16'h0003;
        checks++;
        if (pcs.size() < 6) begin
            errors++;
            $display("FAIL jump_count: got %0d accepted expected at least 6", pcs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (pcs[i] !== exp_pc[i]) begin
                    errors++;
                    $display("FAIL jump_seq[%0d]: got pc=%h expected pc=%h", i, pcs[i], exp_pc[i]);
                end
            end
            checks++;
            if (insts[3] !== 16'hA010) begin errors++; $display("FAIL jump_word: got %h expected a010", insts[3]); end
        end
    endtask

    task automatic test_midreset();
        next_cycle();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got v=%b expected 1", inst_valid); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 16'h0 || inst_pc !== 8'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got req=%b v=%b inst=%h pc=%h expected all 0", imem_req, inst_valid, inst, inst_pc);
        end
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL midrst_restart: got req=%b addr=%h expected req=1 addr=00", imem_req, imem_addr);
        end
        next_cycle();
        next_cycle(); #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00) begin errors++; $display("FAIL midrst_pc0: got v=%b pc=%h expected v=1 pc=00", inst_valid, inst_pc); end
        next_cycle(); #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h01) begin errors++; $display("FAIL midrst_pc1: got v=%b pc=%h expected v=1 pc=01", inst_valid, inst_pc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_wrap();
        test_jump();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
